read_seq: RTL and testbench

READ_SEQ -- requirements
Module: read_seq

---
 rtl/read_seq.sv | 165 ++++++++++++++++
 tb/tb_read_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/read_seq.sv
// read_seq: streams a burst of register-file words, read one at a time
// through the sig port, into a small output FIFO with valid/ready handshake.
// Optional feature macro: CLEAR_AFTER_READ_EN -- when defined, every word
// read is written back to zero through the same sig port before the next read.
module read_seq #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 7,
    parameter int NUM_REGS   = 100,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        count,
    input  logic              mac_active,
    output logic [ADDR_W-1:0] sig_addr,
    output logic              read_sig,
    output logic              write_sig,
    output logic [DATA_W-1:0] data_from_sig,
    input  logic [DATA_W-1:0] data_to_sig,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]     DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0]     LAST_PTR  = PW'(FIFO_DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NREG_A    = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [8:0]        NREG_C    = 9'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
`ifdef CLEAR_AFTER_READ_EN
        S_CLEAR,
`endif
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_cap_addr;
    logic [7:0]          r_remaining;
    logic                r_err;
    logic                r_done_pulse;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [CW-1:0]       r_fill;

    logic w_start_bad;
    logic w_start_ok;
    logic w_accept;
    logic w_push;
    logic w_pop;

    // A request is out of range if it overruns the register file or starts past it.
    assign w_start_bad = ({1'b0, count} > NREG_C) || ({1'b0, base_addr} >= NREG_A);
    assign w_start_ok  = (count != 8'd0) && !w_start_bad;
    // Only issue when the slot for this word is guaranteed free at capture time.
    assign w_accept    = (r_state == S_ISSUE) && !mac_active && (r_fill < DEPTH_C);
    assign w_push      = (r_state == S_CAPTURE);
    assign w_pop       = (r_fill != '0) && out_ready;

    // Next-state and sig-port/status outputs.
    always_comb begin
        w_state_next  = r_state;
        read_sig      = 1'b0;
        write_sig     = 1'b0;
        data_from_sig = '0;
        sig_addr      = '0;
        case (r_state)
            S_IDLE: begin
                if (start && w_start_ok) w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                sig_addr = r_addr;
                read_sig = w_accept;
                if (w_accept) w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
`ifdef CLEAR_AFTER_READ_EN
                w_state_next = S_CLEAR;
`else
                w_state_next = (r_remaining == 8'd0) ? S_DRAIN : S_ISSUE;
`endif
            end
`ifdef CLEAR_AFTER_READ_EN
            S_CLEAR: begin
                sig_addr  = r_cap_addr;
                write_sig = !mac_active;
                if (!mac_active) w_state_next = (r_remaining == 8'd0) ? S_DRAIN : S_ISSUE;
            end
`endif
            S_DRAIN: begin
                if (r_fill == '0) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done_pulse || ((r_state == S_DRAIN) && (r_fill == '0));
    assign err       = r_err;
    assign out_valid = (r_fill != '0);
    assign out_data  = out_valid ? r_mem[r_rptr] : '0;

    // State, burst counters and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_cap_addr   <= '0;
            r_remaining  <= '0;
            r_err        <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_done_pulse <= 1'b0;
            if (r_state == S_IDLE && start) begin
                r_addr       <= base_addr;
                r_remaining  <= count;
                r_err        <= (count != 8'd0) && w_start_bad;
                r_done_pulse <= !w_start_ok;
            end
            if (w_accept) begin
                r_cap_addr  <= r_addr;
                r_addr      <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
                r_remaining <= r_remaining - 8'd1;
            end
        end
    end

    // FIFO storage; contents need no reset since the fill count masks them.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= data_to_sig;
    end

    // FIFO pointers and fill level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule

// File: tb/tb_read_seq.sv
// tb_read_seq: directed and randomized bursts against a queue-based model of
// the expected address/word stream, with a behavioural register file.
module tb_read_seq;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 7;
    localparam int NUM_REGS   = 100;
    localparam int FIFO_DEPTH = 2;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        count;
    logic              mac_active;
    logic [ADDR_W-1:0] sig_addr;
    logic              read_sig;
    logic              write_sig;
    logic [DATA_W-1:0] data_from_sig;
    logic [DATA_W-1:0] data_to_sig;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              err;

    read_seq #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .mac_active(mac_active), .sig_addr(sig_addr), .read_sig(read_sig),
        .write_sig(write_sig), .data_from_sig(data_from_sig), .data_to_sig(data_to_sig),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: base contents plus a per-entry "cleared" flag.
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              cleared [NUM_REGS];
    logic              tb_init;

    // Sig-port behaviour: read data one cycle after the strobe, writes mark entries cleared.
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < NUM_REGS; i++) cleared[i] <= 1'b0;
        end else begin
            if (read_sig) data_to_sig <= cleared[sig_addr] ? '0 : regs[sig_addr];
            if (write_sig && data_from_sig == '0) cleared[sig_addr] <= 1'b1;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    int n_rd     = 0;
    int n_pop    = 0;
    int n_done   = 0;
    int aq[$];
    logic [DATA_W-1:0] dq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rd_val(input int a);
        return cleared[a] ? '0 : regs[a];
    endfunction

    // One clock cycle: observe at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            if (read_sig) begin
                if (aq.size() == 0) check("unexpected_read", 32'(sig_addr), 32'hFFFF);
                else check("read_addr", 32'(sig_addr), 32'(aq.pop_front()));
                check("read_while_full", 32'((n_rd - n_pop) < FIFO_DEPTH), 32'd1);
                n_rd++;
            end
            if (out_valid && out_ready) begin
                if (dq.size() == 0) check("unexpected_word", 32'(out_data), 32'hFFFFF);
                else check("out_data", 32'(out_data), 32'(dq.pop_front()));
                n_pop++;
            end
            if (write_sig) check("clear_data", 32'(data_from_sig), 32'd0);
`ifndef CLEAR_AFTER_READ_EN
            if (write_sig || data_from_sig != '0) check("no_write", 32'(write_sig), 32'd0);
`endif
            if (done) n_done++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_read_sig"},  32'(read_sig), 32'd0);
        check({tag, "_write_sig"}, 32'(write_sig), 32'd0);
        check({tag, "_sig_addr"},  32'(sig_addr), 32'd0);
        check({tag, "_wdata"},     32'(data_from_sig), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data), 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_done"},      32'(done), 32'd0);
        check({tag, "_err"},       32'(err), 32'd0);
    endtask

    // rmode: 0 ready high, 1 toggle, 2 random.  mmode: 0 idle, 1 five-cycle window, 2 random.
    task automatic run_burst(input int base, input int cnt, input int rmode, input int mmode);
        bit exp_bad;
        int d0;
        int cyc;
        exp_bad = (cnt != 0) && ((cnt > NUM_REGS) || (base >= NUM_REGS));
        if (cnt != 0 && !exp_bad) begin
            for (int i = 0; i < cnt; i++) begin
                aq.push_back((base + i) % NUM_REGS);
                dq.push_back(rd_val((base + i) % NUM_REGS));
            end
        end
        d0 = n_done;
        start = 1'b1;
        base_addr = ADDR_W'(base);
        count = 8'(cnt);
        tick();
        start = 1'b0;
        if (cnt == 0 || exp_bad) begin
            check("nop_done", 32'(done), 32'd1);
            check("nop_err", 32'(err), 32'(exp_bad));
            check("nop_busy", 32'(busy), 32'd0);
            tick();
            check("nop_done_once", 32'(n_done - d0), 32'd1);
            check("nop_done_low", 32'(done), 32'd0);
            check("nop_err_sticky", 32'(err), 32'(exp_bad));
        end else begin
            check("burst_busy", 32'(busy), 32'd1);
            cyc = 0;
            while (n_done == d0 && cyc < 5000) begin
                out_ready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
                mac_active = (mmode == 1) ? 1'(cyc >= 1 && cyc <= 5) :
                             (mmode == 2) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
                #1;
                if (mac_active) check("mac_hold", 32'(read_sig), 32'd0);
                tick();
                cyc++;
            end
            mac_active = 1'b0;
            out_ready  = 1'b1;
            check("done_once", 32'(n_done - d0), 32'd1);
            check("end_busy", 32'(busy), 32'd0);
            check("end_done_low", 32'(done), 32'd0);
            check("end_err", 32'(err), 32'd0);
            check("words_left", 32'(dq.size()), 32'd0);
            check("reads_left", 32'(aq.size()), 32'd0);
        end
        $display("burst base=%0d count=%0d ready_mode=%0d mac_mode=%0d err=%0b dones=%0d",
                 base, cnt, rmode, mmode, err, n_done - d0);
    endtask

    initial begin
        int d0;
        int r0;
        int guard;
        reset = 1'b1; tb_init = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        mac_active = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'($urandom_range(1, 16'hFFFF));
        regs[10] = 16'd1; regs[11] = 16'd2; regs[12] = 16'd3; regs[13] = 16'd4;
        tick();
        tick();
        tb_init = 1'b0;
        check_idle_zero("reset");
        reset = 1'b0;
        tick();
        check_idle_zero("post_reset");

        run_burst(10, 4, 0, 0);
        run_burst(98, 4, 0, 0);
        run_burst(30, 4, 1, 0);
        run_burst(40, 4, 0, 1);
        run_burst(0, 101, 0, 0);
        run_burst(0, 0, 0, 0);
        run_burst(100, 1, 0, 0);
        run_burst(0, 0, 0, 0);
        run_burst(0, 100, 2, 2);

        // Reset mid-burst after the second accepted read.
        d0 = n_done;
        r0 = n_rd;
        aq.delete(); dq.delete();
        for (int i = 0; i < 8; i++) begin
            aq.push_back(50 + i);
            dq.push_back(rd_val(50 + i));
        end
        start = 1'b1; base_addr = ADDR_W'(50); count = 8'd8;
        tick();
        start = 1'b0;
        guard = 0;
        while (n_rd < r0 + 2 && guard < 100) begin
            tick();
            guard++;
        end
        check("mid_reads", 32'(n_rd - r0), 32'd2);
        reset = 1'b1;
        tick();
        check_idle_zero("mid_reset");
        reset = 1'b0;
        aq.delete(); dq.delete();
        n_rd = 0; n_pop = 0;
        tick();
        tick();
        check("mid_no_done", 32'(n_done - d0), 32'd0);
        $display("burst base=50 count=8 reset after 2 reads dones=%0d", n_done - d0);

        for (int k = 0; k < 10; k++) begin
            run_burst($urandom_range(0, NUM_REGS - 1), $urandom_range(1, 20),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end
        // Start while busy must be ignored: pulse start mid-burst.
        aq.delete(); dq.delete();
        for (int i = 0; i < 3; i++) begin
            aq.push_back(20 + i);
            dq.push_back(rd_val(20 + i));
        end
        d0 = n_done;
        start = 1'b1; base_addr = ADDR_W'(20); count = 8'd3;
        tick();
        base_addr = ADDR_W'(70); count = 8'd5;
        tick();
        start = 1'b0;
        guard = 0;
        while (n_done == d0 && guard < 200) begin
            tick();
            guard++;
        end
        check("busy_start_done", 32'(n_done - d0), 32'd1);
        check("busy_start_words", 32'(dq.size() + aq.size()), 32'd0);
        $display("burst base=20 count=3 with start while busy dones=%0d", n_done - d0);

`ifdef CLEAR_AFTER_READ_EN
        for (int a = 10; a < 14; a++) check("cleared_reg", 32'(cleared[a]), 32'd1);
`else
        begin
            int nclr;
            nclr = 0;
            for (int a = 0; a < NUM_REGS; a++) if (cleared[a]) nclr++;
            check("regs_untouched", 32'(nclr), 32'd0);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
